// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the single write port of the asynchronous FIFO among NUM_REQ
// producers in the write clock domain. A round-robin search picks an owner
// from IDLE. The owner then keeps the port for up to BURST_LEN accepted
// words, or until it drops its request. Every release returns to IDLE for
// one bubble cycle. The previous owner has the lowest priority at the next
// arbitration.
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   i_data,
    input  logic                           i_full,
    output logic [NUM_REQ-1:0]             o_ack,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_wr_en,
    output logic [DATA_SIZE-1:0]           o_wr_data,
    output logic                           o_busy
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = OW + 1;
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        rrPtr_q, rrPtr_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [CW-1:0]        count_q, count_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;

    logic                 pickFound;
    logic [OW-1:0]        pickIdx;
    logic [PW-1:0]        candIdx;
    logic                 ownerReq;
    logic [DATA_SIZE-1:0] ownerData;
    logic                 accept;
    logic                 lastBeat;
    logic                 release_w;

    // Cyclic search for the first active requester at or after the round-robin pointer
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        candIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candIdx = {1'b0, rrPtr_q} + PW'(i);
            if (candIdx >= PW'(NUM_REQ)) begin
                candIdx = candIdx - PW'(NUM_REQ);
            end
            if (!pickFound && i_req[candIdx[OW-1:0]]) begin
                pickFound = 1'b1;
                pickIdx   = candIdx[OW-1:0];
            end
        end
    end

    // Owner request and data are picked through the one-hot grant, so both read as zero while idle
    always_comb begin
        ownerReq  = |(i_req & grant_q);
        ownerData = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                ownerData = ownerData | i_data[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Write path: a word is taken only from the owner, only when the FIFO has room
    always_comb begin
        accept    = (state_q == GRANT) && ownerReq && !i_full;
        lastBeat  = (count_q == CW'(BURST_LEN - 1));
        release_w = (state_q == GRANT) && ((accept && lastBeat) || !ownerReq);
        o_wr_en   = accept;
        o_ack     = accept ? grant_q : '0;
        o_wr_data = ownerData;
        o_grant   = grant_q;
        o_busy    = busy_q;
    end

    // Next-state logic: arbitration in IDLE, beat counting and release in GRANT
    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        owner_d = owner_q;
        count_d = count_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d          = GRANT;
                    owner_d          = pickIdx;
                    count_d          = '0;
                    grant_d          = '0;
                    grant_d[pickIdx] = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            GRANT: begin
                if (accept) begin
                    count_d = count_q + CW'(1);
                end
                if (release_w) begin
                    state_d = IDLE;
                    count_d = '0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    if (owner_q == OW'(NUM_REQ - 1)) begin
                        rrPtr_d = '0;
                    end else begin
                        rrPtr_d = owner_q + OW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with registered grant and busy; reset drops any burst in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            rrPtr_q <= '0;
            owner_q <= '0;
            count_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rrPtr_q <= rrPtr_d;
            owner_q <= owner_d;
            count_q <= count_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

endmodule
